// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// A combinational lookup of fetch_pc provides a same-cycle taken/target
// prediction. Resolved branches update the table on the rising edge, and two
// saturating performance counters track accepted updates and mispredicts.
module branch_predictor #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              predict_taken,
  output logic [DATA_W-1:0] predict_target,
  input  logic              update_valid,
  input  logic [DATA_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [DATA_W-1:0] update_target,
  input  logic              update_mispredict,
  input  logic              flush,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [TAG_W-1:0]  tag_d    [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];
  logic [1:0]        ctr_d    [DEPTH];
  logic [DATA_W-1:0] target_q [DEPTH];
  logic [DATA_W-1:0] target_d [DEPTH];
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic              f_hit, u_hit;

  // pc[1:0] and bits above the tag field take no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc, update_pc};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[TAG_W+IDX_W+1:IDX_W+2];

  // Same-cycle lookup of the fetch PC against the registered (pre-update) table.
  always_comb begin
    f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    predict_taken  = f_hit && ctr_q[f_idx][1];
    predict_target = predict_taken ? target_q[f_idx] : '0;
  end

  // Table next state: counter training on hit, allocation on taken miss; flush overrides.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (flush) begin
      valid_d = '0;
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          target_d[u_idx] = update_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        ctr_d[u_idx]    = 2'b10;
        target_d[u_idx] = update_target;
      end
    end
  end

  // Saturating performance counters; they count updates even when flush drops them.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_valid) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + CNT_ONE;
      if (update_mispredict && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + CNT_ONE;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q            <= '0;
      tag_q              <= '{default: '0};
      ctr_q              <= '{default: 2'b01};
      target_q           <= '{default: '0};
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      ctr_q              <= ctr_d;
      target_q           <= target_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
